fetch_flow_ctrl: RTL and testbench
==================================

Name: fetch_flow_ctrl

Overview:
- Flow controller that sequences the instruction-fetch stage: drives the back-and-keep (bk), jump-flag and jump-pc controls into IF, plus the flush and hold controls for the IF/ID and ID/EX pipeline registers.
- Arbitrates three redirect sources into one IF command stream: EX-stage branch/jump resolution, Icache miss/refill and ID-stage load-use stall.
- Guarantees that IF sees at most one command per cycle.

Parameters:
- MISS_TIMEOUT, 64, refill-wait cycles in MISS after which fc_err_o is raised.
- CNT_W, 8, width of the miss-wait counter; must satisfy 2^CNT_W > MISS_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- if_pc_i  in  32  current IF fetch PC (IF if_pc_o).
- icache_valid_i  in  1  Icache lookup result valid this cycle.
- icache_hit_i  in  1  lookup hit; qualified by icache_valid_i.
- icache_miss_pc_i  in  32  PC of the lookup that missed.
- icache_refill_done_i  in  1  one-cycle pulse when refill completes.
- ex_jump_flag_i  in  1  EX resolved taken branch or jump.
- ex_jump_pc_i  in  32  redirect target.
- id_stall_i  in  1  ID load-use hazard; level signal.
- fc_bk_if_o  out  1  to IF: back and keep.
- fc_jump_flag_if_o  out  1  to IF: load fc_jump_pc_if_o.
- fc_jump_pc_if_o  out  32  to IF: redirect PC.
- fc_flush_ifid_o  out  1  invalidate IF/ID register.
- fc_flush_idex_o  out  1  invalidate ID/EX register.
- fc_hold_ifid_o  out  1  hold IF/ID contents.
- fc_busy_o  out  1  state != RUN.
- fc_err_o  out  1  sticky miss-timeout error.

Behaviour:
- Registered state: state (RUN, MISS, STALL, REPLAY), replay_pc[31:0], redir_pc[31:0], redir_pend, miss_cnt[CNT_W-1:0], err.
- Outputs are combinational from state and inputs.
- On reset (rst_n=0 at a clock edge): state=RUN, replay_pc=0, redir_pc=0, redir_pend=0, miss_cnt=0, err=0. While reset is asserted, every output is 0.
- fc_jump_pc_if_o is 0 whenever fc_jump_flag_if_o=0.
- RUN, priority from highest to lowest:
  - ex_jump_flag_i: jump_flag=1, jump_pc=ex_jump_pc_i, flush_ifid=1, flush_idex=1. Stay in RUN. Any concurrent miss or stall is wrong-path and is ignored.
  - Else icache_valid_i & !icache_hit_i: bk=1, flush_ifid=1. replay_pc<=icache_miss_pc_i, miss_cnt<=0. Next state MISS.
  - Else id_stall_i: bk=1, hold_ifid=1, flush_idex=1 (bubble). replay_pc<=if_pc_i. Next state STALL.
  - Else all outputs 0.
- MISS:
  - bk=1 and flush_ifid=1 every cycle.
  - miss_cnt increments and saturates. When miss_cnt reaches MISS_TIMEOUT, err<=1.
  - ex_jump_flag_i: redir_pc<=ex_jump_pc_i, redir_pend<=1, flush_idex=1. A later jump overwrites redir_pc.
  - icache_refill_done_i: next state REPLAY. Refill done and a jump in the same cycle: both are taken and the jump is latched.
- STALL:
  - bk=1, hold_ifid=1, flush_idex=1 while id_stall_i=1.
  - ex_jump_flag_i: latched as in MISS; flush_ifid=1 also asserted.
  - id_stall_i=0: next state REPLAY.
- REPLAY (exactly one cycle):
  - jump_flag=1, flush_ifid=1.
  - jump_pc = ex_jump_pc_i if ex_jump_flag_i, else redir_pc if redir_pend, else replay_pc. If ex_jump_flag_i, flush_idex=1.
  - redir_pend<=0. Next state RUN.
- Invariants:
  - bk and jump_flag are never both 1.
  - hold_ifid and flush_ifid are both 1 only in STALL with a latched redirect; flush wins.
- Latency: a miss seen in cycle N gives bk in cycle N; refill done in cycle M gives a replay jump in cycle M+1.
- err is cleared only by reset.
- Reset mid-MISS or mid-STALL discards replay_pc and redir_pend.

Decomposition:
- Shared package fc_pkg: the state encoding (2-bit enum RUN=0, MISS=1, STALL=2, REPLAY=3) and the constant RESET_PC=32'h0.
- No sub-module. The saturating miss counter stays inline.

Test Plan:
- Jump in RUN: ex_jump_flag_i=1, ex_jump_pc_i=0x100 -> same cycle jump_flag=1, jump_pc=0x100, both flushes=1; fc_busy_o stays 0.
- Miss then refill: miss with icache_miss_pc_i=0x40 -> bk=1 for 5 cycles; refill_done on the 5th -> next cycle jump_flag=1, jump_pc=0x40, then RUN.
- Jump during miss: miss at 0x40, jump to 0x200 in MISS cycle 2, refill later -> REPLAY jump_pc=0x200, flush_idex pulsed in cycle 2, redir_pend cleared.
- Load-use stall: if_pc_i=0x1C, id_stall_i high for 2 cycles -> bk, hold_ifid and flush_idex for 2 cycles, then jump_pc=0x1C.
- Simultaneous events: jump to 0x80, miss and stall in the same RUN cycle -> only the jump is issued, state stays RUN; jump to 0x90 during REPLAY -> jump_pc=0x90.
- Timeout and reset: no refill for 64 cycles -> fc_err_o=1 and stays high; rst_n=0 for one edge -> all outputs 0, state RUN, fc_err_o=0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the instruction-fetch flow controller.
package fc_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_STALL  = 2'd2,
        ST_REPLAY = 2'd3
    } fc_state_e;

    localparam logic [PC_W-1:0] RESET_PC = 32'h0;

endpackage

// File: rtl/fetch_flow_ctrl.sv
// Sequences IF redirects: arbitrates EX jumps, Icache miss/refill and ID load-use
// stalls into a single back-and-keep / jump command stream plus pipeline flush/hold.
module fetch_flow_ctrl
    import fc_pkg::*;
#(
    parameter int unsigned MISS_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc_i,
    input  logic            icache_valid_i,
    input  logic            icache_hit_i,
    input  logic [PC_W-1:0] icache_miss_pc_i,
    input  logic            icache_refill_done_i,
    input  logic            ex_jump_flag_i,
    input  logic [PC_W-1:0] ex_jump_pc_i,
    input  logic            id_stall_i,
    output logic            fc_bk_if_o,
    output logic            fc_jump_flag_if_o,
    output logic [PC_W-1:0] fc_jump_pc_if_o,
    output logic            fc_flush_ifid_o,
    output logic            fc_flush_idex_o,
    output logic            fc_hold_ifid_o,
    output logic            fc_busy_o,
    output logic            fc_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(MISS_TIMEOUT);

    fc_state_e        state_q,      state_d;
    logic [PC_W-1:0]  replay_pc_q,  replay_pc_d;
    logic [PC_W-1:0]  redir_pc_q,   redir_pc_d;
    logic             redir_pend_q, redir_pend_d;
    logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;
    logic             err_q,        err_d;

    logic icache_miss;
    assign icache_miss = icache_valid_i & ~icache_hit_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            replay_pc_q  <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
            miss_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            replay_pc_q  <= replay_pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
            miss_cnt_q   <= miss_cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        replay_pc_d  = replay_pc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        miss_cnt_d   = miss_cnt_q;
        err_d        = err_q;
        case (state_q)
            ST_RUN: begin
                // A resolved jump makes any concurrent miss or stall wrong-path.
                if (!ex_jump_flag_i) begin
                    if (icache_miss) begin
                        replay_pc_d = icache_miss_pc_i;
                        miss_cnt_d  = '0;
                        state_d     = ST_MISS;
                    end else if (id_stall_i) begin
                        replay_pc_d = if_pc_i;
                        state_d     = ST_STALL;
                    end
                end
            end
            ST_MISS: begin
                if (miss_cnt_q != CNT_MAX) begin
                    miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
                if (miss_cnt_q >= CNT_TIMEOUT) begin
                    err_d = 1'b1;
                end
                if (ex_jump_flag_i) begin
                    redir_pc_d   = ex_jump_pc_i;
                    redir_pend_d = 1'b1;
                end
                if (icache_refill_done_i) begin
                    state_d = ST_REPLAY;
                end
            end
            ST_STALL: begin
                if (ex_jump_flag_i) begin
                    redir_pc_d   = ex_jump_pc_i;
                    redir_pend_d = 1'b1;
                end
                if (!id_stall_i) begin
                    state_d = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                redir_pend_d = 1'b0;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        fc_bk_if_o        = 1'b0;
        fc_jump_flag_if_o = 1'b0;
        fc_jump_pc_if_o   = '0;
        fc_flush_ifid_o   = 1'b0;
        fc_flush_idex_o   = 1'b0;
        fc_hold_ifid_o    = 1'b0;
        fc_busy_o         = 1'b0;
        fc_err_o          = 1'b0;
        if (rst_n) begin
            fc_busy_o = (state_q != ST_RUN);
            fc_err_o  = err_q;
            case (state_q)
                ST_RUN: begin
                    if (ex_jump_flag_i) begin
                        fc_jump_flag_if_o = 1'b1;
                        fc_jump_pc_if_o   = ex_jump_pc_i;
                        fc_flush_ifid_o   = 1'b1;
                        fc_flush_idex_o   = 1'b1;
                    end else if (icache_miss) begin
                        fc_bk_if_o      = 1'b1;
                        fc_flush_ifid_o = 1'b1;
                    end else if (id_stall_i) begin
                        fc_bk_if_o      = 1'b1;
                        fc_hold_ifid_o  = 1'b1;
                        fc_flush_idex_o = 1'b1;
                    end
                end
                ST_MISS: begin
                    fc_bk_if_o      = 1'b1;
                    fc_flush_ifid_o = 1'b1;
                    fc_flush_idex_o = ex_jump_flag_i;
                end
                ST_STALL: begin
                    fc_bk_if_o      = id_stall_i;
                    fc_hold_ifid_o  = id_stall_i;
                    fc_flush_idex_o = id_stall_i | ex_jump_flag_i;
                    fc_flush_ifid_o = ex_jump_flag_i;
                end
                ST_REPLAY: begin
                    fc_jump_flag_if_o = 1'b1;
                    fc_flush_ifid_o   = 1'b1;
                    fc_flush_idex_o   = ex_jump_flag_i;
                    // A live EX redirect beats a latched one, which beats the replay PC.
                    if (ex_jump_flag_i) begin
                        fc_jump_pc_if_o = ex_jump_pc_i;
                    end else if (redir_pend_q) begin
                        fc_jump_pc_if_o = redir_pc_q;
                    end else begin
                        fc_jump_pc_if_o = replay_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Randomized bench for fetch_flow_ctrl against a behavioural model of the
// redirect rules, with directed sequences for the documented scenarios.
module tb_fetch_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc_i;
    logic        icache_valid_i;
    logic        icache_hit_i;
    logic [31:0] icache_miss_pc_i;
    logic        icache_refill_done_i;
    logic        ex_jump_flag_i;
    logic [31:0] ex_jump_pc_i;
    logic        id_stall_i;
    logic        fc_bk_if_o;
    logic        fc_jump_flag_if_o;
    logic [31:0] fc_jump_pc_if_o;
    logic        fc_flush_ifid_o;
    logic        fc_flush_idex_o;
    logic        fc_hold_ifid_o;
    logic        fc_busy_o;
    logic        fc_err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: what the controller is waiting for, plus remembered PCs.
    bit          w_refill, w_stall, do_replay;
    int          wait_cycles;
    bit          err_seen;
    bit          have_redir;
    logic [31:0] resume_pc, redir_target;

    fetch_flow_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .if_pc_i              (if_pc_i),
        .icache_valid_i       (icache_valid_i),
        .icache_hit_i         (icache_hit_i),
        .icache_miss_pc_i     (icache_miss_pc_i),
        .icache_refill_done_i (icache_refill_done_i),
        .ex_jump_flag_i       (ex_jump_flag_i),
        .ex_jump_pc_i         (ex_jump_pc_i),
        .id_stall_i           (id_stall_i),
        .fc_bk_if_o           (fc_bk_if_o),
        .fc_jump_flag_if_o    (fc_jump_flag_if_o),
        .fc_jump_pc_if_o      (fc_jump_pc_if_o),
        .fc_flush_ifid_o      (fc_flush_ifid_o),
        .fc_flush_idex_o      (fc_flush_idex_o),
        .fc_hold_ifid_o       (fc_hold_ifid_o),
        .fc_busy_o            (fc_busy_o),
        .fc_err_o             (fc_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        w_refill     = 0;
        w_stall      = 0;
        do_replay    = 0;
        wait_cycles  = 0;
        err_seen     = 0;
        have_redir   = 0;
        resume_pc    = 32'h0;
        redir_target = 32'h0;
    endtask

    // Drive one cycle, compare all outputs against the model, advance the model.
    task automatic run_cycle(input bit rst, input logic [31:0] pc, input bit vld, input bit hit,
                             input logic [31:0] mpc, input bit refill, input bit jf,
                             input logic [31:0] jpc, input bit stall);
        bit e_bk, e_jf, e_fi, e_fe, e_hold, e_busy, e_err;
        logic [31:0] e_pc;
        bit miss;
        @(negedge clk);
        rst_n = ~rst; if_pc_i = pc; icache_valid_i = vld; icache_hit_i = hit;
        icache_miss_pc_i = mpc; icache_refill_done_i = refill;
        ex_jump_flag_i = jf; ex_jump_pc_i = jpc; id_stall_i = stall;
        #1;
        miss = vld && !hit;
        {e_bk, e_jf, e_fi, e_fe, e_hold, e_busy, e_err} = '0;
        e_pc = 32'h0;
        if (!rst) begin
            e_busy = w_refill || w_stall || do_replay;
            e_err  = err_seen;
            if (do_replay) begin
                e_jf = 1; e_fi = 1; e_fe = jf;
                e_pc = jf ? jpc : (have_redir ? redir_target : resume_pc);
            end else if (w_refill) begin
                e_bk = 1; e_fi = 1; e_fe = jf;
            end else if (w_stall) begin
                e_bk = stall; e_hold = stall; e_fe = stall || jf; e_fi = jf;
            end else if (jf) begin
                e_jf = 1; e_pc = jpc; e_fi = 1; e_fe = 1;
            end else if (miss) begin
                e_bk = 1; e_fi = 1;
            end else if (stall) begin
                e_bk = 1; e_hold = 1; e_fe = 1;
            end
        end
        check_val("bk",        32'(fc_bk_if_o),        32'(e_bk));
        check_val("jump_flag", 32'(fc_jump_flag_if_o), 32'(e_jf));
        check_val("jump_pc",   fc_jump_pc_if_o,        e_pc);
        check_val("flush_ifid",32'(fc_flush_ifid_o),   32'(e_fi));
        check_val("flush_idex",32'(fc_flush_idex_o),   32'(e_fe));
        check_val("hold_ifid", 32'(fc_hold_ifid_o),    32'(e_hold));
        check_val("busy",      32'(fc_busy_o),         32'(e_busy));
        check_val("err",       32'(fc_err_o),          32'(e_err));
        if (fc_bk_if_o && fc_jump_flag_if_o) check_val("bk_and_jump", 32'd1, 32'd0);

        if (rst) begin
            model_reset();
        end else if (do_replay) begin
            do_replay  = 0;
            have_redir = 0;
        end else if (w_refill) begin
            if (wait_cycles >= 64) err_seen = 1;
            if (wait_cycles < 255) wait_cycles++;
            if (jf) begin have_redir = 1; redir_target = jpc; end
            if (refill) begin w_refill = 0; do_replay = 1; end
        end else if (w_stall) begin
            if (jf) begin have_redir = 1; redir_target = jpc; end
            if (!stall) begin w_stall = 0; do_replay = 1; end
        end else if (!jf) begin
            if (miss) begin
                w_refill = 1; resume_pc = mpc; wait_cycles = 0;
            end else if (stall) begin
                w_stall = 1; resume_pc = pc;
            end
        end
    endtask

    // Idle cycle with no events.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        run_cycle(1, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        run_cycle(1, 32'hFFFF, 1, 0, 32'h44, 1, 1, 32'h55, 1);
        idle(2);
        // Jump in RUN
        run_cycle(0, 32'h10, 0, 0, 0, 0, 1, 32'h100, 0);
        // Miss at 0x40, refill on the 5th bk cycle
        run_cycle(0, 32'h14, 1, 0, 32'h40, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(0, 32'h14, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 32'h14, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // Jump during miss
        run_cycle(0, 32'h14, 1, 0, 32'h40, 0, 0, 0, 0);
        run_cycle(0, 32'h14, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 32'h14, 0, 0, 0, 0, 1, 32'h200, 0);
        run_cycle(0, 32'h14, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // Load-use stall
        run_cycle(0, 32'h1C, 0, 0, 0, 0, 0, 0, 1);
        run_cycle(0, 32'h1C, 0, 0, 0, 0, 0, 0, 1);
        run_cycle(0, 32'h1C, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Simultaneous events in RUN, then jump during REPLAY
        run_cycle(0, 32'h20, 1, 0, 32'h60, 0, 1, 32'h80, 1);
        run_cycle(0, 32'h80, 1, 0, 32'h60, 0, 0, 0, 0);
        run_cycle(0, 32'h80, 0, 0, 0, 1, 0, 0, 0);
        run_cycle(0, 32'h80, 0, 0, 0, 0, 1, 32'h90, 0);
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            bit r_rst, r_vld, r_hit, r_ref, r_jf, r_st;
            r_rst = ($urandom_range(0, 99) == 0);
            r_vld = ($urandom_range(0, 1) == 1);
            r_hit = ($urandom_range(0, 9) != 0);
            r_ref = ($urandom_range(0, 4) == 0);
            r_jf  = ($urandom_range(0, 11) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            run_cycle(r_rst, $urandom & 32'hFFFF_FFFC, r_vld, r_hit, $urandom & 32'hFFFF_FFFC,
                      r_ref, r_jf, $urandom & 32'hFFFF_FFFC, r_st);
        end

        // Timeout, stickiness after refill, then reset clears it
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 32'h30, 1, 0, 32'h300, 0, 0, 0, 0);
        for (int i = 0; i < 80; i++) run_cycle(0, 32'h30, 0, 0, 0, 0, (i == 40), 32'h340, (i % 7 == 0));
        run_cycle(0, 32'h30, 0, 0, 0, 1, 0, 0, 0);
        idle(3);
        check_val("err_sticky", 32'(fc_err_o), 32'd1);
        run_cycle(1, 32'h30, 1, 0, 32'h300, 0, 1, 32'h400, 1);
        idle(2);
        check_val("err_cleared", 32'(fc_err_o), 32'd0);
        // Reset mid-stall discards the pending replay
        run_cycle(0, 32'h50, 0, 0, 0, 0, 0, 0, 1);
        run_cycle(0, 32'h50, 0, 0, 0, 0, 1, 32'h500, 1);
        run_cycle(1, 32'h50, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
